serial_rx_align: RTL and testbench

Serial receiver and byte aligner for the phy serial lane: deserializes the one-bit stream produced by the phy transmitter's parallel-to-serial stage, finds byte alignment from the 0xBC idle/comma character, and declares the lane active after a configurable run of consecutive 0xBC bytes. It then presents recovered 8-bit data with a valid flag and drops 0xBC fill bytes. It sits between the serial line and the phy receiver's byte-to-lane distribution logic, running in the serial clock domain.

---
 rtl/serial_rx_align_if.sv | 10 +
 rtl/serial_rx_align.sv | 112 +++++++++++
 tb/tb_serial_rx_align.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/serial_rx_align_if.sv
// Serial lane bundle: one-bit line into the aligner, recovered byte stream out.
interface serial_rx_align_if;
  logic       data_in;
  logic [7:0] out_byte;
  logic       valid_out;
  logic       active;

  modport master (output data_in, input out_byte, valid_out, active);
  modport slave  (input data_in, output out_byte, valid_out, active);
endinterface

// File: rtl/serial_rx_align.sv
// Serial deserializer and comma-based byte aligner; drops comma fill once the lane is active.
module serial_rx_align #(
  parameter int unsigned BC_COUNT = 4,
  parameter logic [7:0]  COMMA    = 8'hBC
) (
  input logic               clk_32f,
  input logic               reset,
  serial_rx_align_if.slave  lane
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned BC_CNT_W  = 4;
  localparam int unsigned STATE_W   = 2;

  localparam logic [STATE_W-1:0] SEARCH = 2'd0;
  localparam logic [STATE_W-1:0] COUNT  = 2'd1;
  localparam logic [STATE_W-1:0] ACTIVE = 2'd2;

  logic [STATE_W-1:0]   state_q,    state_n;
  logic [BYTE_W-1:0]    sr_q,       sr_n;
  logic [BIT_CNT_W-1:0] bit_cnt_q,  bit_cnt_n;
  logic [BC_CNT_W-1:0]  bc_cnt_q,   bc_cnt_n;
  logic [BYTE_W-1:0]    out_byte_q, out_byte_n;
  logic                 valid_q,    valid_n;
  logic                 active_q,   active_n;

  logic                 boundary;
  logic                 comma_hit;
  logic [BC_CNT_W-1:0]  bc_inc;

  assign boundary  = (bit_cnt_q == BIT_CNT_W'(7));
  assign comma_hit = (sr_q == COMMA);
  assign bc_inc    = bc_cnt_q + BC_CNT_W'(1);

  // State and datapath registers
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q    <= SEARCH;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      bc_cnt_q   <= '0;
      out_byte_q <= '0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_n;
      sr_q       <= sr_n;
      bit_cnt_q  <= bit_cnt_n;
      bc_cnt_q   <= bc_cnt_n;
      out_byte_q <= out_byte_n;
      valid_q    <= valid_n;
      active_q   <= active_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state_q;
    sr_n       = {sr_q[BYTE_W-2:0], lane.data_in};
    bit_cnt_n  = bit_cnt_q;
    bc_cnt_n   = bc_cnt_q;
    out_byte_n = out_byte_q;
    valid_n    = valid_q;

    case (state_q)
      SEARCH: begin
        // Any bit phase may match; the match edge becomes bit 0 of the byte grid
        valid_n = 1'b0;
        if (comma_hit) begin
          bit_cnt_n = '0;
          bc_cnt_n  = BC_CNT_W'(1);
          state_n   = (BC_COUNT == 1) ? ACTIVE : COUNT;
        end
      end
      COUNT: begin
        valid_n   = 1'b0;
        bit_cnt_n = bit_cnt_q + BIT_CNT_W'(1);
        if (boundary) begin
          if (comma_hit) begin
            bc_cnt_n = bc_inc;
            if (bc_inc == BC_CNT_W'(BC_COUNT)) state_n = ACTIVE;
          end else begin
            bc_cnt_n = '0;
            state_n  = SEARCH;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_n = bit_cnt_q + BIT_CNT_W'(1);
        if (boundary) begin
          if (comma_hit) begin
            valid_n = 1'b0;
          end else begin
            out_byte_n = sr_q;
            valid_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = SEARCH;
      end
    endcase

    active_n = (state_n == ACTIVE);
  end

  assign lane.out_byte  = out_byte_q;
  assign lane.valid_out = valid_q;
  assign lane.active    = active_q;

endmodule

// File: tb/tb_serial_rx_align.sv
// Scoreboard bench for serial_rx_align: BC_COUNT=4 and BC_COUNT=1 instances fed the same line.
module tb_serial_rx_align;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;

  always #5 clk_32f = ~clk_32f;

  serial_rx_align_if lane4 ();
  serial_rx_align_if lane1 ();

  serial_rx_align #(.BC_COUNT(4), .COMMA(8'hBC)) dut4 (
    .clk_32f (clk_32f),
    .reset   (reset),
    .lane    (lane4)
  );

  serial_rx_align #(.BC_COUNT(1), .COMMA(8'hBC)) dut1 (
    .clk_32f (clk_32f),
    .reset   (reset),
    .lane    (lane1)
  );

  typedef struct {
    string      tag;
    bit         sel;   // 0: dut4, 1: dut1
    logic       act;
    logic       vld;
    logic [7:0] byt;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_n   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, want, edge_n);
    end
  endtask

  task automatic push_exp(input string tag, input bit sel, input logic act,
                          input logic vld, input logic [7:0] byt, input int due);
    exp_t e;
    e.tag = tag; e.sel = sel; e.act = act; e.vld = vld; e.byt = byt; e.due = due;
    sb.push_back(e);
  endtask

  // Compare every entry whose due edge has just passed
  task automatic service();
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == edge_n) begin
        if (sb[i].sel) begin
          chk_eq({sb[i].tag, "_act"}, 32'(lane1.active),    32'(sb[i].act));
          chk_eq({sb[i].tag, "_vld"}, 32'(lane1.valid_out), 32'(sb[i].vld));
          chk_eq({sb[i].tag, "_byte"}, 32'(lane1.out_byte), 32'(sb[i].byt));
        end else begin
          chk_eq({sb[i].tag, "_act"}, 32'(lane4.active),    32'(sb[i].act));
          chk_eq({sb[i].tag, "_vld"}, 32'(lane4.valid_out), 32'(sb[i].vld));
          chk_eq({sb[i].tag, "_byte"}, 32'(lane4.out_byte), 32'(sb[i].byt));
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic step(input logic b);
    lane4.data_in = b;
    lane1.data_in = b;
    @(posedge clk_32f);
    edge_n++;
    #1;
    service();
  endtask

  // Last bit lands at edge N: result due after N+1, and must still hold after N+8
  task automatic send_byte(input logic [7:0] b, input string tag,
                           input logic act, input logic vld, input logic [7:0] ob);
    for (int i = 7; i >= 0; i--) step(b[i]);
    push_exp(tag, 1'b0, act, vld, ob, edge_n + 1);
    push_exp({tag, "_hold"}, 1'b0, act, vld, ob, edge_n + 8);
  endtask

  task automatic do_reset(input string tag);
    sb.delete();
    reset = 1'b1;
    step(1'($urandom_range(0, 1)));
    reset = 1'b0;
    chk_eq({tag, "_act4"},  32'(lane4.active),    32'h0);
    chk_eq({tag, "_vld4"},  32'(lane4.valid_out), 32'h0);
    chk_eq({tag, "_byte4"}, 32'(lane4.out_byte),  32'h0);
    chk_eq({tag, "_act1"},  32'(lane1.active),    32'h0);
  endtask

  task automatic send_commas4(input string tag);
    send_byte(8'hBC, {tag, "_c1"}, 1'b0, 1'b0, 8'h00);
    send_byte(8'hBC, {tag, "_c2"}, 1'b0, 1'b0, 8'h00);
    send_byte(8'hBC, {tag, "_c3"}, 1'b0, 1'b0, 8'h00);
    send_byte(8'hBC, {tag, "_c4"}, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    lane4.data_in = 1'b0;
    lane1.data_in = 1'b0;

    // Idle line never aligns
    do_reset("rst0");
    for (int i = 0; i < 100; i++) begin
      step(1'b0);
      chk_eq("idle_act",  32'(lane4.active),    32'h0);
      chk_eq("idle_vld",  32'(lane4.valid_out), 32'h0);
      chk_eq("idle_byte", 32'(lane4.out_byte),  32'h0);
    end

    // Aligned lock, data, comma drop
    do_reset("rst1");
    send_commas4("t1");
    send_byte(8'h5A, "t1_5a", 1'b1, 1'b1, 8'h5A);
    send_byte(8'hC3, "t1_c3", 1'b1, 1'b1, 8'hC3);
    send_byte(8'hBC, "t1_bc", 1'b1, 1'b0, 8'hC3);
    send_byte(8'h01, "t1_01", 1'b1, 1'b1, 8'h01);
    repeat (12) step(1'b0);

    // Bit-shifted phase
    do_reset("rst2");
    repeat (3) step(1'($urandom_range(0, 1)));
    chk_eq("t2_junk_act", 32'(lane4.active), 32'h0);
    send_commas4("t2");
    send_byte(8'hAA, "t2_aa", 1'b1, 1'b1, 8'hAA);
    repeat (12) step(1'b0);

    // Broken comma run restarts alignment
    do_reset("rst3");
    send_byte(8'hBC, "t3_c1", 1'b0, 1'b0, 8'h00);
    send_byte(8'hBC, "t3_c2", 1'b0, 1'b0, 8'h00);
    send_byte(8'h33, "t3_33", 1'b0, 1'b0, 8'h00);
    send_commas4("t3r");
    send_byte(8'h77, "t3_77", 1'b1, 1'b1, 8'h77);
    repeat (12) step(1'b0);

    // Reset mid-byte while active
    do_reset("rst4");
    send_commas4("t4");
    send_byte(8'h12, "t4_12a", 1'b1, 1'b1, 8'h12);
    send_byte(8'h12, "t4_12b", 1'b1, 1'b1, 8'h12);
    step(1'b0); step(1'b0); step(1'b0);
    do_reset("t4_midrst");
    send_commas4("t4r");
    send_byte(8'h12, "t4_12c", 1'b1, 1'b1, 8'h12);
    repeat (12) step(1'b0);

    // Single-comma lock on dut1; same stream leaves dut4 searching
    do_reset("rst5");
    send_byte(8'hBC, "t5_bc4", 1'b0, 1'b0, 8'h00);
    push_exp("t5_bc1", 1'b1, 1'b1, 1'b0, 8'h00, edge_n + 1);
    push_exp("t5_bc1_hold", 1'b1, 1'b1, 1'b0, 8'h00, edge_n + 8);
    send_byte(8'h9F, "t5_9f4", 1'b0, 1'b0, 8'h00);
    push_exp("t5_9f1", 1'b1, 1'b1, 1'b1, 8'h9F, edge_n + 1);
    push_exp("t5_9f1_hold", 1'b1, 1'b1, 1'b1, 8'h9F, edge_n + 8);
    repeat (12) step(1'b0);

    chk_eq("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
